// File: rtl/exception_ctrl.sv
// Precise exception / interrupt arbiter feeding the CP0 register file.
// Ports: MEM-stage instruction info and fault flags, raw hw_int lines,
//   CP0 Status/Cause/EPC in; CP0 write vector, flush, PC redirect, busy out.
module exception_ctrl #(
    parameter int              WIDTH        = 32,
    parameter logic [WIDTH-1:0] EXC_VECTOR  = 32'hBFC00380,
    parameter int              FLUSH_CYCLES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             mem_valid,
    input  logic [WIDTH-1:0] mem_pc,
    input  logic             mem_bd,
    input  logic [WIDTH-1:0] mem_badaddr,
    input  logic             exc_if_adel,
    input  logic             exc_ri,
    input  logic             exc_ov,
    input  logic             exc_sys,
    input  logic             exc_bp,
    input  logic             exc_adel,
    input  logic             exc_ades,
    input  logic             mem_eret,
    input  logic [5:0]       hw_int,
    input  logic [WIDTH-1:0] status_in,
    input  logic [WIDTH-1:0] cause_in,
    input  logic [WIDTH-1:0] epc_in,
    output logic [WIDTH-1:0] cp0_we,
    output logic [WIDTH-1:0] cp0_epc,
    output logic [WIDTH-1:0] cp0_badaddr,
    output logic [4:0]       cp0_exccode,
    output logic             cp0_bd,
    output logic [7:0]       cp0_int_en,
    output logic             cp0_exl,
    output logic             cp0_ie,
    output logic [5:0]       cp0_hw_int,
    output logic             flush,
    output logic             redirect_valid,
    output logic [WIDTH-1:0] redirect_pc,
    output logic             busy
);

    localparam int CW = $clog2(FLUSH_CYCLES + 1);

    typedef enum logic [1:0] {IDLE, EXC, ERET, FLUSH} state_t;

    state_t        state, state_nx;
    logic [CW-1:0] cnt, cnt_nx;
    logic [5:0]    sync1;
    logic          int_pend;
    logic          any_exc;
    logic          take_exc;
    logic          take_eret;
    logic [4:0]    code;
    logic          unused_bits;

    assign unused_bits = ^{status_in[WIDTH-1:16], status_in[7:2],
                           cause_in[WIDTH-1:10], cause_in[7:0]};

    // Interrupts are masked while EXL is set or IE is clear.
    always_comb begin
        int_pend = (|{cp0_hw_int & status_in[15:10],
                      cause_in[9:8] & status_in[9:8]})
                   & status_in[0] & ~status_in[1];
        any_exc  = int_pend | exc_if_adel | exc_ri | exc_ov | exc_sys
                 | exc_bp | exc_adel | exc_ades;
        code = 5'd0;
        priority case (1'b1)
            int_pend:    code = 5'd0;
            exc_if_adel: code = 5'd4;
            exc_ri:      code = 5'd10;
            exc_ov:      code = 5'd12;
            exc_sys:     code = 5'd8;
            exc_bp:      code = 5'd9;
            exc_adel:    code = 5'd4;
            exc_ades:    code = 5'd5;
            default:     code = 5'd0;
        endcase
        take_exc  = (state == IDLE) && mem_valid && any_exc;
        take_eret = (state == IDLE) && mem_valid && mem_eret && !any_exc;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
        end
    end

    always_comb begin
        state_nx       = state;
        cnt_nx         = cnt;
        cp0_we         = '0;
        flush          = 1'b0;
        redirect_valid = 1'b0;
        unique case (state)
            IDLE: begin
                cnt_nx = '0;
                if (take_exc)       state_nx = EXC;
                else if (take_eret) state_nx = ERET;
            end
            EXC: begin
                cp0_we[14:12]  = 3'b111;
                cp0_we[8]      = (cp0_exccode == 5'd4) ||
                                 (cp0_exccode == 5'd5);
                flush          = 1'b1;
                redirect_valid = 1'b1;
                cnt_nx         = CW'(1);
                state_nx       = (FLUSH_CYCLES == 1) ? IDLE : FLUSH;
            end
            ERET: begin
                cp0_we[12]     = 1'b1;
                flush          = 1'b1;
                redirect_valid = 1'b1;
                cnt_nx         = CW'(1);
                state_nx       = (FLUSH_CYCLES == 1) ? IDLE : FLUSH;
            end
            FLUSH: begin
                flush = 1'b1;
                if (cnt == CW'(FLUSH_CYCLES - 1)) begin
                    cnt_nx   = '0;
                    state_nx = IDLE;
                end else begin
                    cnt_nx = cnt + CW'(1);
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    assign busy = (state != IDLE);

    // Event context is captured on the accepting edge so the CP0
    // write in EXC sees stable values regardless of MEM-stage churn.
    always_ff @(posedge clk) begin
        if (!rst) begin
            sync1       <= '0;
            cp0_hw_int  <= '0;
            cp0_epc     <= '0;
            cp0_badaddr <= '0;
            cp0_exccode <= '0;
            cp0_bd      <= 1'b0;
            cp0_int_en  <= '0;
            cp0_exl     <= 1'b0;
            cp0_ie      <= 1'b0;
            redirect_pc <= '0;
        end else begin
            sync1      <= hw_int;
            cp0_hw_int <= sync1;
            if (take_exc) begin
                cp0_epc     <= mem_bd ? mem_pc - WIDTH'(4) : mem_pc;
                cp0_bd      <= mem_bd;
                cp0_badaddr <= exc_if_adel ? mem_pc : mem_badaddr;
                cp0_exccode <= code;
                cp0_int_en  <= status_in[15:8];
                cp0_ie      <= status_in[0];
                cp0_exl     <= 1'b1;
                redirect_pc <= EXC_VECTOR;
            end else if (take_eret) begin
                cp0_exl     <= 1'b0;
                redirect_pc <= epc_in;
            end
        end
    end

endmodule
